// File: rtl/mbus_arbiter.sv
// -----------------------------------------------------------------------------
// mbus_arbiter
//
// Arbitrates N_CH requester channels onto a single bus master port. A grant is
// chosen in IDLE (fixed priority or round-robin). The winner's command is then
// latched onto the bus and held in BUSY until the slave acks or the optional
// timeout expires. DONE produces a one-cycle o_ready (and o_err on timeout) to
// the granted channel. Every output comes straight from a flop.
//
// Parameters
//   N_CH     : number of requester channels (2..8)
//   XLEN     : address / data width
//   ARB_MODE : 0 = fixed priority (lowest index wins), 1 = round-robin
//   TIMEOUT  : BUSY cycles before abort, 0 = wait forever
//
// Ports
//   i_clk, i_rst       : rising-edge clock, asynchronous active-low reset
//   i_req/i_wen        : per-channel request and write enable
//   i_addr/i_wd        : per-channel address / write data, channel k at [k*XLEN +: XLEN]
//   i_byte_en          : per-channel byte enables, channel k at [k*4 +: 4]
//   o_ready/o_err      : one-cycle completion / timeout flags per channel
//   o_rd_data          : shared read data, valid while o_ready is high
//   o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en : bus master command
//   i_ack, i_rd_data   : slave completion and read data
// -----------------------------------------------------------------------------
module mbus_arbiter #(
    parameter int N_CH     = 2,
    parameter int XLEN     = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_CH-1:0]      i_req,
    input  logic [N_CH-1:0]      i_wen,
    input  logic [N_CH*XLEN-1:0] i_addr,
    input  logic [N_CH*XLEN-1:0] i_wd,
    input  logic [N_CH*4-1:0]    i_byte_en,
    output logic [N_CH-1:0]      o_ready,
    output logic [N_CH-1:0]      o_err,
    output logic [XLEN-1:0]      o_rd_data,
    output logic                 o_bus_en,
    output logic                 o_wr_en,
    output logic [XLEN-1:0]      o_addr,
    output logic [XLEN-1:0]      o_wr_data,
    output logic [3:0]           o_byte_en,
    input  logic                 i_ack,
    input  logic [XLEN-1:0]      i_rd_data
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    // The counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Per-channel views of the packed command buses
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] ch_addr [N_CH];
    logic [XLEN-1:0] ch_wd   [N_CH];
    logic [3:0]      ch_be   [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign ch_addr[gi] = i_addr[gi*XLEN +: XLEN];
        assign ch_wd[gi]   = i_wd[gi*XLEN +: XLEN];
        assign ch_be[gi]   = i_byte_en[gi*4 +: 4];
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    state_t          state_reg,      state_next;
    logic            bus_en_reg,     bus_en_next;
    logic            wr_en_reg,      wr_en_next;
    logic [XLEN-1:0] addr_reg,       addr_next;
    logic [XLEN-1:0] wr_data_reg,    wr_data_next;
    logic [3:0]      byte_en_reg,    byte_en_next;
    logic [XLEN-1:0] rd_data_reg,    rd_data_next;
    logic [N_CH-1:0] ready_reg,      ready_next;
    logic [N_CH-1:0] err_reg,        err_next;
    logic [GW-1:0]   grant_reg,      grant_next;
    logic [GW-1:0]   last_grant_reg, last_grant_next;
    logic [CW-1:0]   cnt_reg,        cnt_next;
    logic            timed_out_reg,  timed_out_next;

    // ---------------------------------------------------------------------
    // Grant selection
    // ---------------------------------------------------------------------
    logic [GW-1:0] grant;
    logic          found;
    int            rr_idx;

    always_comb begin
        grant  = '0;
        found  = 1'b0;
        rr_idx = 0;
        if (ARB_MODE == 0) begin
            // Walk downwards so the lowest requesting index is written last.
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    grant = GW'(i);
                end
            end
        end else begin
            // Search starts just past the previous winner and wraps.
            for (int i = 0; i < N_CH; i++) begin
                rr_idx = (int'(last_grant_reg) + 1 + i) % N_CH;
                if (!found && i_req[rr_idx[GW-1:0]]) begin
                    grant = rr_idx[GW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg      <= IDLE;
            bus_en_reg     <= 1'b0;
            wr_en_reg      <= 1'b0;
            addr_reg       <= '0;
            wr_data_reg    <= '0;
            byte_en_reg    <= '0;
            rd_data_reg    <= '0;
            ready_reg      <= '0;
            err_reg        <= '0;
            grant_reg      <= '0;
            last_grant_reg <= GW'(N_CH - 1);
            cnt_reg        <= '0;
            timed_out_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bus_en_reg     <= bus_en_next;
            wr_en_reg      <= wr_en_next;
            addr_reg       <= addr_next;
            wr_data_reg    <= wr_data_next;
            byte_en_reg    <= byte_en_next;
            rd_data_reg    <= rd_data_next;
            ready_reg      <= ready_next;
            err_reg        <= err_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            timed_out_reg  <= timed_out_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        bus_en_next     = bus_en_reg;
        wr_en_next      = wr_en_reg;
        addr_next       = addr_reg;
        wr_data_next    = wr_data_reg;
        byte_en_next    = byte_en_reg;
        rd_data_next    = rd_data_reg;
        ready_next      = '0;
        err_next        = '0;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        timed_out_next  = timed_out_reg;

        unique case (state_reg)
            IDLE: begin
                if (|i_req) begin
                    grant_next      = grant;
                    last_grant_next = grant;
                    bus_en_next     = 1'b1;
                    wr_en_next      = i_wen[grant];
                    addr_next       = ch_addr[grant];
                    wr_data_next    = ch_wd[grant];
                    byte_en_next    = ch_be[grant];
                    cnt_next        = '0;
                    timed_out_next  = 1'b0;
                    state_next      = BUSY;
                end
            end

            BUSY: begin
                if (i_ack) begin
                    // An ack on the timeout cycle still counts as success.
                    rd_data_next   = wr_en_reg ? '0 : i_rd_data;
                    bus_en_next    = 1'b0;
                    timed_out_next = 1'b0;
                    state_next     = DONE;
                end else if (TIMEOUT > 0 && cnt_reg == CW'(TIMEOUT - 1)) begin
                    rd_data_next   = '0;
                    bus_en_next    = 1'b0;
                    timed_out_next = 1'b1;
                    state_next     = DONE;
                end else if (TIMEOUT > 0) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DONE: begin
                // Completion is flagged on the way out so o_rd_data has been
                // stable for a full cycle before o_ready appears.
                ready_next[grant_reg] = 1'b1;
                err_next[grant_reg]   = timed_out_reg;
                state_next            = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_ready   = ready_reg;
    assign o_err     = err_reg;
    assign o_rd_data = rd_data_reg;
    assign o_bus_en  = bus_en_reg;
    assign o_wr_en   = wr_en_reg;
    assign o_addr    = addr_reg;
    assign o_wr_data = wr_data_reg;
    assign o_byte_en = byte_en_reg;

endmodule

// File: tb/tb_mbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mbus_arbiter
//
// Two arbiter instances share one stimulus set; 'sel' routes requests and acks
// to the active one while the other sees nothing and idles.
//   A: N_CH=2, fixed priority, no timeout
//   B: N_CH=4, round-robin, TIMEOUT=4
// -----------------------------------------------------------------------------
module tb_mbus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic [3:0]   req;
    logic [3:0]   wen;
    logic [127:0] addr;
    logic [127:0] wd;
    logic [15:0]  be;
    logic         ack;
    logic [31:0]  rd;

    always #5 clk = ~clk;

    // Instance A wiring
    logic [1:0]  req_a, ready_a, err_a;
    logic        ack_a, bus_en_a, wr_en_a;
    logic [31:0] rdd_a, addr_a, wdat_a;
    logic [3:0]  be_a;

    assign req_a = sel ? 2'b00 : req[1:0];
    assign ack_a = ~sel & ack;

    mbus_arbiter #(.N_CH(2), .XLEN(32), .ARB_MODE(0), .TIMEOUT(0)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_req(req_a), .i_wen(wen[1:0]),
        .i_addr(addr[63:0]), .i_wd(wd[63:0]), .i_byte_en(be[7:0]),
        .o_ready(ready_a), .o_err(err_a), .o_rd_data(rdd_a),
        .o_bus_en(bus_en_a), .o_wr_en(wr_en_a), .o_addr(addr_a),
        .o_wr_data(wdat_a), .o_byte_en(be_a),
        .i_ack(ack_a), .i_rd_data(rd)
    );

    // Instance B wiring
    logic [3:0]  req_b, ready_b, err_b;
    logic        ack_b, bus_en_b, wr_en_b;
    logic [31:0] rdd_b, addr_b, wdat_b;
    logic [3:0]  be_b;

    assign req_b = sel ? req : 4'b0000;
    assign ack_b = sel & ack;

    mbus_arbiter #(.N_CH(4), .XLEN(32), .ARB_MODE(1), .TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_req(req_b), .i_wen(wen),
        .i_addr(addr), .i_wd(wd), .i_byte_en(be),
        .o_ready(ready_b), .o_err(err_b), .o_rd_data(rdd_b),
        .o_bus_en(bus_en_b), .o_wr_en(wr_en_b), .o_addr(addr_b),
        .o_wr_data(wdat_b), .o_byte_en(be_b),
        .i_ack(ack_b), .i_rd_data(rd)
    );

    // Outputs of whichever instance is active
    logic [3:0]  ready_m, err_m, be_m;
    logic        bus_en_m, wr_en_m;
    logic [31:0] rdd_m, addr_m, wdat_m;

    always_comb begin
        if (sel) begin
            ready_m = ready_b;   err_m  = err_b;   be_m   = be_b;
            bus_en_m = bus_en_b; wr_en_m = wr_en_b;
            rdd_m = rdd_b;       addr_m = addr_b;  wdat_m = wdat_b;
        end else begin
            ready_m = {2'b00, ready_a}; err_m = {2'b00, err_a}; be_m = be_a;
            bus_en_m = bus_en_a; wr_en_m = wr_en_a;
            rdd_m = rdd_a;       addr_m = addr_a;  wdat_m = wdat_a;
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state: last granted channel per instance.
    int lg [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected grant from the arbitration rules.
    function automatic int pick(input int s, input logic [3:0] m);
        int n;
        n = (s != 0) ? 4 : 2;
        if (s == 0) begin
            for (int i = 0; i < n; i++)
                if (m[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++)
                if (m[(lg[s] + k) % n]) return (lg[s] + k) % n;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int k = 0; k < 4; k++) begin
            addr[k*32 +: 32] = ($urandom & 32'hFFFF_FFF0) | 32'(k);
            wd[k*32 +: 32]   = $urandom;
            be[k*4 +: 4]     = 4'($urandom);
        end
        rd = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_en"},  32'(bus_en_m), 32'd0);
        chk({tag, "_wr_en"},   32'(wr_en_m),  32'd0);
        chk({tag, "_addr"},    addr_m,        32'd0);
        chk({tag, "_wr_data"}, wdat_m,        32'd0);
        chk({tag, "_byte_en"}, 32'(be_m),     32'd0);
        chk({tag, "_rd_data"}, rdd_m,         32'd0);
        chk({tag, "_ready"},   32'(ready_m),  32'd0);
        chk({tag, "_err"},     32'(err_m),    32'd0);
    endtask

    // One complete transaction. Called at a negedge with the active instance
    // idle; returns at the negedge of the o_ready cycle with req cleared.
    task automatic run_txn(input int s, input logic [3:0] m, input logic [3:0] w,
                           input int ack_at, input int g, input logic e, input string tag);
        int          tmo, last_c;
        logic [31:0] ea, ed, erd;
        logic [3:0]  eb;
        logic        ew;
        tmo    = (s != 0) ? 4 : 0;
        last_c = (tmo > 0 && ack_at > tmo - 1) ? tmo - 1 : ack_at;
        ea  = addr[g*32 +: 32];
        ed  = wd[g*32 +: 32];
        eb  = be[g*4 +: 4];
        ew  = w[g];
        erd = (e || ew) ? 32'd0 : rd;

        sel = s[0];
        chk({tag, "_idle_bus_en"}, 32'(bus_en_m), 32'd0);
        req = m;
        wen = w;
        ack = 1'b0;
        @(negedge clk);
        for (int c = 0; c <= last_c; c++) begin
            chk({tag, "_busy_bus_en"},  32'(bus_en_m), 32'd1);
            chk({tag, "_busy_addr"},    addr_m,        ea);
            chk({tag, "_busy_wr_en"},   32'(wr_en_m),  32'(ew));
            chk({tag, "_busy_wr_data"}, wdat_m,        ed);
            chk({tag, "_busy_byte_en"}, 32'(be_m),     32'(eb));
            chk({tag, "_busy_ready"},   32'(ready_m),  32'd0);
            // Scramble requester inputs: the latched command must not move.
            req  = 4'($urandom);
            wen  = 4'($urandom);
            addr = {$urandom, $urandom, $urandom, $urandom};
            wd   = {$urandom, $urandom, $urandom, $urandom};
            be   = 16'($urandom);
            if (c == ack_at) ack = 1'b1;
            @(negedge clk);
        end
        ack = 1'b0;
        // DONE: bus released, no completion yet, requests still ignored
        chk({tag, "_done_bus_en"}, 32'(bus_en_m), 32'd0);
        chk({tag, "_done_ready"},  32'(ready_m),  32'd0);
        @(negedge clk);
        chk({tag, "_ready"},        32'(ready_m),  32'(4'b0001 << g));
        chk({tag, "_err"},          32'(err_m),    e ? 32'(4'b0001 << g) : 32'd0);
        chk({tag, "_rd_data"},      rdd_m,         erd);
        chk({tag, "_ready_bus_en"}, 32'(bus_en_m), 32'd0);
        req = 4'b0000;
        lg[s] = g;
        $display("txn %s: inst=%0d req=%b wen=%b ack_at=%0d grant=%0d err=%0d rd=%h",
                 tag, s, m, w, ack_at, g, e, erd);
    endtask

    typedef struct {
        logic       s;
        logic [3:0] m;
        logic [3:0] w;
        int         ack_at;
        int         g;
        logic       e;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // inst, req, wen, ack cycle, expected grant, expected err
        tbl[0]  = '{1'b0, 4'b0001, 4'b0000, 0, 0, 1'b0};  // basic read
        tbl[1]  = '{1'b0, 4'b0011, 4'b0000, 1, 0, 1'b0};  // fixed priority
        tbl[2]  = '{1'b0, 4'b0011, 4'b0000, 0, 0, 1'b0};  // ch1 starves
        tbl[3]  = '{1'b0, 4'b0010, 4'b0010, 2, 1, 1'b0};  // ch1 write alone
        tbl[4]  = '{1'b0, 4'b0011, 4'b0011, 0, 0, 1'b0};  // write, be 0011
        tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 0, 0, 1'b0};  // round-robin
        tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 0, 1, 1'b0};
        tbl[7]  = '{1'b1, 4'b1111, 4'b0000, 0, 2, 1'b0};
        tbl[8]  = '{1'b1, 4'b1111, 4'b0000, 0, 3, 1'b0};
        tbl[9]  = '{1'b1, 4'b1111, 4'b0000, 0, 0, 1'b0};  // wrap
        tbl[10] = '{1'b1, 4'b1111, 4'b0000, 9, 1, 1'b1};  // timeout
        tbl[11] = '{1'b1, 4'b1111, 4'b0000, 3, 2, 1'b0};  // ack on last cycle wins
        tbl[12] = '{1'b1, 4'b0101, 4'b0000, 1, 0, 1'b0};  // wrap past 3
        tbl[13] = '{1'b1, 4'b0100, 4'b0000, 0, 2, 1'b0};
        tbl[14] = '{1'b1, 4'b1010, 4'b1111, 2, 3, 1'b0};  // write
        tbl[15] = '{1'b1, 4'b0011, 4'b0000, 9, 0, 1'b1};  // timeout, ch0

        rst = 1'b0; sel = 1'b0; req = '0; wen = '0; addr = '0; wd = '0; be = '0;
        ack = 1'b0; rd = '0;
        lg[0] = 1; lg[1] = 3;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        sel = 1'b0; #1; check_all_zero("rst_a");
        sel = 1'b1; #1; check_all_zero("rst_b");
        @(negedge clk);
        rst = 1'b1;

        // No requests: stays idle
        sel = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_bus_en", 32'(bus_en_m), 32'd0);
            chk("idle_ready",  32'(ready_m),  32'd0);
        end

        // Table-driven vectors
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 4; k++) begin
                addr[k*32 +: 32] = 32'h100 + 32'(k) * 32'h10 + 32'(r) * 32'h1000;
                wd[k*32 +: 32]   = 32'h12345678 + 32'(k) * 32'h1111_0000;
                be[k*4 +: 4]     = 4'(3 + k);
            end
            rd = 32'hDEADBEEF + 32'(r);
            run_txn(int'(tbl[r].s), tbl[r].m, tbl[r].w, tbl[r].ack_at,
                    tbl[r].g, tbl[r].e, $sformatf("vec%0d", r));
        end

        // Reset during BUSY: silent abort, round-robin restarts at channel 0
        rand_data();
        rd = 32'hCAFEF00D;
        run_txn(1, 4'b1111, 4'b0000, 0, pick(1, 4'b1111), 1'b0, "pre_rst");
        rand_data();
        req = 4'b1111; wen = 4'b1111;
        @(negedge clk);
        chk("mid_busy_bus_en", 32'(bus_en_m), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_ready",  32'(ready_m),  32'd0);
            chk("in_rst_bus_en", 32'(bus_en_m), 32'd0);
        end
        req = 4'b0000; ack = 1'b0; rst = 1'b1;
        lg[0] = 1; lg[1] = 3;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready_m), 32'd0);
        chk("post_rst_err",   32'(err_m),   32'd0);
        rand_data();
        run_txn(1, 4'b1111, 4'b0000, 1, pick(1, 4'b1111), 1'b0, "after_rst");

        // Randomized transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            int         s, ack_at, g;
            logic [3:0] m, w;
            s      = int'($urandom_range(0, 1));
            m      = (s != 0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(1, 3));
            w      = 4'($urandom);
            ack_at = (s != 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 5));
            g      = pick(s, m);
            rand_data();
            run_txn(s, m, w, ack_at, g, (s != 0) && (ack_at > 3), $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
